// File: rtl/axil_write_arbiter.sv
// Arbitrates NUM_REQ local write requesters onto one AXI-lite write master (AW/W/B).
// Define AXIL_WRITE_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module axil_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [1:0]                    rsp_resp,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_WIDTH-1:0]         m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);
    // state | meaning
    // IDLE  | no transaction; grant on any req_valid
    // WRITE | AW and W handshakes in flight, tracked independently
    // RESP  | bready high, waiting for the B response
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, RESP = 2'd2} state_t;

    state_t                  state, state_nx;
    logic                    any_req;
    logic [IDW-1:0]          win;
    logic                    aw_fire, w_fire, aw_done, w_done, b_fire;
    logic                    awvalid_d, wvalid_d, bready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [IDW-1:0]          grant_d;
    logic [1:0]              resp_d;
    logic [NUM_REQ-1:0]      req_ready_d, rsp_valid_d;

    assign any_req = |req_valid;
    assign aw_fire = m_axi_awvalid & m_axi_awready;
    assign w_fire  = m_axi_wvalid & m_axi_wready;
    // a channel counts as done if it already completed or completes on this edge
    assign aw_done = ~m_axi_awvalid | m_axi_awready;
    assign w_done  = ~m_axi_wvalid | m_axi_wready;
    assign b_fire  = m_axi_bvalid & m_axi_bready;
    assign busy    = (state != IDLE);

`ifdef AXIL_WRITE_ARB_RR_EN
    localparam logic [IDW:0] RR_N = (IDW+1)'(NUM_REQ);
    logic [IDW-1:0] ptr;
    logic [IDW:0]   rr_idx;

    // walk from the farthest offset back to ptr so the nearest valid requester wins
    always_comb begin
        win    = '0;
        rr_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (rr_idx >= RR_N) rr_idx = rr_idx - RR_N;
            if (req_valid[rr_idx[IDW-1:0]]) win = rr_idx[IDW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (state == IDLE && any_req)
            ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[k]) win = IDW'(k);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            grant_id      <= '0;
            rsp_resp      <= 2'b00;
            req_ready     <= '0;
            rsp_valid     <= '0;
        end else begin
            state         <= state_nx;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_wdata   <= wdata_d;
            grant_id      <= grant_d;
            rsp_resp      <= resp_d;
            req_ready     <= req_ready_d;
            rsp_valid     <= rsp_valid_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = WRITE;
            WRITE:   if (aw_done && w_done) state_nx = RESP;
            RESP:    if (b_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        awvalid_d   = m_axi_awvalid;
        wvalid_d    = m_axi_wvalid;
        bready_d    = m_axi_bready;
        awaddr_d    = m_axi_awaddr;
        wdata_d     = m_axi_wdata;
        grant_d     = grant_id;
        resp_d      = rsp_resp;
        req_ready_d = '0;
        rsp_valid_d = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    awaddr_d         = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d          = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    awvalid_d        = 1'b1;
                    wvalid_d         = 1'b1;
                    grant_d          = win;
                    req_ready_d[win] = 1'b1;
                end
            end
            WRITE: begin
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                if (aw_done && w_done) bready_d = 1'b1;
            end
            RESP: begin
                if (b_fire) begin
                    bready_d              = 1'b0;
                    rsp_valid_d[grant_id] = 1'b1;
                    resp_d                = m_axi_bresp;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Self-checking bench for axil_write_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_axil_write_arbiter;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int GW = $clog2(NR);
`ifdef AXIL_WRITE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready, rsp_valid;
    logic [1:0]       rsp_resp;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic [AW-1:0]    m_axi_awaddr;
    logic             m_axi_awvalid;
    logic [DW-1:0]    m_axi_wdata;
    logic             m_axi_wvalid;
    logic             m_axi_bready;
    logic             awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]       bresp = 2'b00;

    axil_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
        .grant_id(grant_id), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          e_busy = 0, e_awvalid = 0, e_wvalid = 0, e_bready = 0;
    logic [AW-1:0] e_awaddr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [1:0]    e_resp = '0;
    logic [NR-1:0] e_req_ready = '0, e_rsp_valid = '0;
    int            e_gid = 0, m_ptr = 0, m_g = 0;

    function automatic int pick(input logic [NR-1:0] v, input int start);
        for (int k = 0; k < NR; k++)
            if (v[(start + k) % NR]) return (start + k) % NR;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_busy = 0; e_awvalid = 0; e_wvalid = 0; e_bready = 0;
            e_awaddr = '0; e_wdata = '0; e_resp = '0; e_gid = 0; m_ptr = 0;
            e_req_ready = '0; e_rsp_valid = '0;
        end else begin
            e_req_ready = '0;
            e_rsp_valid = '0;
            if (!e_busy) begin
                if (req_valid != '0) begin
                    m_g = pick(req_valid, RR ? m_ptr : 0);
                    e_gid = m_g;
                    e_awaddr = req_addr[m_g*AW +: AW];
                    e_wdata = req_data[m_g*DW +: DW];
                    e_awvalid = 1; e_wvalid = 1; e_busy = 1;
                    e_req_ready[m_g] = 1'b1;
                    m_ptr = (m_g + 1) % NR;
                end
            end else if (e_bready) begin
                if (bvalid) begin
                    e_bready = 0; e_busy = 0;
                    e_rsp_valid[e_gid] = 1'b1;
                    e_resp = bresp;
                end
            end else begin
                if (e_awvalid && awready) e_awvalid = 0;
                if (e_wvalid && wready) e_wvalid = 0;
                if (!e_awvalid && !e_wvalid) e_bready = 1;
            end
        end
    end

    // ---------------- compare, slave, monitor, requesters ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    int aw_delay = 0, w_delay = 0, b_delay = 0;
    logic b_force = 0;
    logic [1:0] b_resp_val = 2'b00;
    logic hold_mode = 0;
    logic [NR-1:0] req_want = '0;
    logic [NR-1:0] served = '0;
    int acnt = 0, wcnt = 0, bcnt = 0;

    int grants[$];
    int rsp_count = 0, rsp_id = -1, rr_cyc = 0, rsp_cyc = 0;
    logic [1:0] last_resp = '0;
    logic [AW-1:0] aw_seen = '0;
    logic [DW-1:0] w_seen = '0;
    int w_hs_cyc = 0, bready_rise_cyc = 0, bready_cnt = 0, aw_first_cnt = 0;
    logic bready_prev = 0;

    always @(negedge clk) begin
        chk("awvalid",   m_axi_awvalid, e_awvalid);
        chk("wvalid",    m_axi_wvalid,  e_wvalid);
        chk("bready",    m_axi_bready,  e_bready);
        chk("busy",      busy,          e_busy);
        chk("req_ready", req_ready,     e_req_ready);
        chk("rsp_valid", rsp_valid,     e_rsp_valid);
        chk("rsp_resp",  rsp_resp,      e_resp);
        chk("grant_id",  grant_id,      e_gid);
        chk("awaddr",    m_axi_awaddr,  e_awaddr);
        chk("wdata",     m_axi_wdata,   e_wdata);

        acnt = m_axi_awvalid ? acnt + 1 : 0;
        wcnt = m_axi_wvalid  ? wcnt + 1 : 0;
        bcnt = m_axi_bready  ? bcnt + 1 : 0;
        awready = m_axi_awvalid && (acnt > aw_delay);
        wready  = m_axi_wvalid  && (wcnt > w_delay);
        bvalid  = b_force || (m_axi_bready && (bcnt > b_delay));
        bresp   = b_resp_val;

        if (m_axi_awvalid && awready) aw_seen = m_axi_awaddr;
        if (m_axi_wvalid && wready) begin w_seen = m_axi_wdata; w_hs_cyc = cyc; end
        if (!m_axi_awvalid && m_axi_wvalid && busy) aw_first_cnt++;
        if (m_axi_bready && !bready_prev) bready_rise_cyc = cyc;
        if (m_axi_bready) bready_cnt++;
        bready_prev = m_axi_bready;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin grants.push_back(i); rr_cyc = cyc; end
            if (rsp_valid[i]) begin rsp_count++; rsp_id = i; last_resp = rsp_resp; rsp_cyc = cyc; end
        end

        served = (served | (hold_mode ? '0 : req_ready)) & req_want;
        req_valid = req_want & ~served;
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_idle(input int budget);
        repeat (2) @(negedge clk);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            if (!busy && req_valid == '0) break;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            if (rsp_count >= target) break;
        end
        chk("rsp_wait", rsp_count, target);
    endtask

    task automatic wait_grants(input int target, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            if (grants.size() >= target) break;
        end
        chk("grant_wait", grants.size() >= target, 1);
    endtask

    task automatic run_one(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_want = '0;
        req_want[i] = 1'b1;
        wait_rsp(rsp_count + 1, 200);
        req_want = '0;
        wait_idle(50);
    endtask

    int g0, base, rc0;
    int exp_c[5];
    int exp_f[4];

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_grant", grant_id, 0);
        #1 rst = 1'b0;
        @(negedge clk);

        // contention: all four hold their requests
        exp_c = RR ? '{0, 1, 2, 3, 0} : '{0, 0, 0, 0, 0};
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'(i + 8);
            req_data[i*DW +: DW] = 32'hA0 + i;
        end
        g0 = grants.size();
        hold_mode = 1; req_want = '1;
        wait_grants(g0 + 5, 200);
        req_want = '0; hold_mode = 0;
        wait_idle(50);
        for (int k = 0; k < 5; k++) chk("contention_order", grants[g0 + k], exp_c[k]);

        // single write, slave always ready, bvalid one cycle after bready
        b_delay = 1;
        g0 = grants.size();
        run_one(0, 4'h0, 32'hDEADBEEF);
        chk("single_grants", grants.size() - g0, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_resp", last_resp, 2'b00);
        chk("single_latency", rsp_cyc - rr_cyc, 3);
        chk("single_awaddr", aw_seen, 4'h0);
        chk("single_wdata", w_seen, 32'hDEADBEEF);

        // skewed AW/W handshakes
        aw_delay = 1; w_delay = 4;
        base = aw_first_cnt;
        run_one(2, 4'h5, 32'h12345678);
        chk("skew_wdata", w_seen, 32'h12345678);
        chk("skew_awaddr", aw_seen, 4'h5);
        chk("skew_aw_first", aw_first_cnt - base, 3);
        chk("skew_bready_after_w", bready_rise_cyc - w_hs_cyc, 1);

        // response backpressure with SLVERR
        aw_delay = 0; w_delay = 0; b_delay = 5; b_resp_val = 2'b10;
        base = bready_cnt;
        run_one(3, 4'hC, 32'hCAFEF00D);
        chk("bp_resp", last_resp, 2'b10);
        chk("bp_rsp_id", rsp_id, 3);
        chk("bp_bready_cycles", bready_cnt - base, 6);

        // bvalid stuck high outside RESP must be ignored
        aw_delay = 3; b_force = 1; b_resp_val = 2'b01;
        base = bready_cnt;
        run_one(1, 4'h7, 32'h0BADC0DE);
        chk("early_b_resp", last_resp, 2'b01);
        chk("early_b_bready_cycles", bready_cnt - base, 1);
        b_force = 0; aw_delay = 0; b_resp_val = 2'b00;

        // reset while waiting for B
        b_delay = 20;
        req_addr[2*AW +: AW] = 4'h3;
        req_data[2*DW +: DW] = 32'h55AA55AA;
        req_want = 4'b0100;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (m_axi_bready) break;
        end
        chk("rst_mid_bready", m_axi_bready, 1);
        rc0 = rsp_count;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_bready0", m_axi_bready, 0);
        chk("rst_mid_awvalid", m_axi_awvalid, 0);
        chk("rst_mid_wvalid", m_axi_wvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant_id, 0);
        chk("rst_mid_wdata", m_axi_wdata, 0);
        chk("rst_mid_awaddr", m_axi_awaddr, 0);
        chk("rst_mid_req_ready", req_ready, 0);
        req_want = '0;
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        b_delay = 0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_count, rc0);

        // after reset the search restarts at requester 0
        g0 = grants.size();
        req_want = '1;
        wait_rsp(rc0 + 4, 200);
        req_want = '0;
        wait_idle(50);
        for (int k = 0; k < 4; k++) chk("post_rst_order", grants[g0 + k], k);

        // requesters 1 and 3 hold continuously
        exp_f = RR ? '{1, 3, 1, 3} : '{1, 1, 1, 1};
        g0 = grants.size();
        hold_mode = 1; req_want = 4'b1010;
        wait_grants(g0 + 4, 200);
        req_want = '0; hold_mode = 0;
        wait_idle(50);
        for (int k = 0; k < 4; k++) chk("pair_order", grants[g0 + k], exp_f[k]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
